// File: rtl/divider.sv
// divider: sequential restoring unsigned divider producing one quotient bit
// per clock. An operation takes WIDTH iterations after the accepting edge.
// Division by zero finishes in one cycle with all-ones quotient, the dividend
// as remainder, and a div_by_zero flag. The control state is exported for
// debug.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] d_reg, q_reg, r_reg;
  logic [CW-1:0]    count_reg;

  logic             accept, accept_zero, accept_run, last_iter;
  logic [WIDTH:0]   r_shift;
  logic             trial_ok;
  logic [WIDTH-1:0] r_step, q_step;

  // Request decode: operands are taken only in IDLE or DONE.
  always_comb begin
    accept      = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    accept_zero = accept && (divisor == '0);
    accept_run  = accept && (divisor != '0);
    last_iter   = (state_reg == ST_RUN) && (count_reg == CW'(WIDTH - 1));
  end

  // One restoring step. The bit shifted out of R is kept as an extra MSB, so
  // the trial compare stays exact even when the divisor is close to 2^WIDTH.
  always_comb begin
    r_shift  = {r_reg, q_reg[WIDTH-1]};
    trial_ok = (r_shift >= {1'b0, d_reg});
    r_step   = trial_ok ? WIDTH'(r_shift - {1'b0, d_reg}) : r_shift[WIDTH-1:0];
    q_step   = {q_reg[WIDTH-2:0], trial_ok};
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The unused encoding falls back to IDLE.
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept_run) begin
          state_next = ST_RUN;
        end else if (accept_zero) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_next = last_iter ? ST_DONE : ST_RUN;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Working registers: load on accept, then iterate while running.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      count_reg <= '0;
    end else if (accept_run) begin
      d_reg     <= divisor;
      q_reg     <= dividend;
      r_reg     <= '0;
      count_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      q_reg     <= q_step;
      r_reg     <= r_step;
      count_reg <= count_reg + CW'(1);
    end
  end

  // Result registers change only when an operation completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_zero) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_iter) begin
      quotient    <= q_step;
      remainder   <= r_step;
      div_by_zero <= 1'b0;
    end
  end

  // Status outputs decoded purely from the registered state.
  always_comb begin
    busy  = (state_reg == ST_RUN);
    done  = (state_reg == ST_DONE);
    state = state_reg;
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of the divider. Expected results come
// from plain integer division and modulo.
module tb_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div_by_zero, busy, done;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  divider #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One operation with a one-cycle start pulse; operands are scrambled after
  // the accepting edge to show they are not re-sampled.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    int               lat;
    int               busy_cnt;
    logic [WIDTH-1:0] q_before, exp_q, exp_r;
    logic             exp_z;
    if (b == 0) begin
      exp_q = '1; exp_r = a; exp_z = 1'b1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 1'b0;
    end
    q_before = quotient;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick;
    lat      = 1;
    busy_cnt = 0;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == 10) check({tag, "_hold"}, 64'(quotient), 64'(q_before));
      tick;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), (b == 0) ? 64'd1 : 64'(LAT));
    check({tag, "_busy"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'(WIDTH));
    check({tag, "_q"}, 64'(quotient), 64'(exp_q));
    check({tag, "_r"}, 64'(remainder), 64'(exp_r));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(exp_z));
    if (b != 0) begin
      check({tag, "_inv"}, 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      check({tag, "_rlt"}, 64'(remainder < b), 64'd1);
    end
    $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    int               lat;
    logic [WIDTH-1:0] a, b;

    // Reset state while reset is held low.
    #1;
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("idle_state", 64'(state), 64'd0);

    // Directed operations from the plan.
    run_op(32'd100, 32'd7, "d100_7");
    run_op(32'hFFFF_FFFF, 32'd1, "max_1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_max");
    run_op(32'd5, 32'd9, "d5_9");
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, "big_div");
    run_op(32'h0000_1234, 32'd0, "divzero");
    run_op(32'd50, 32'd5, "d50_5");
    tick;
    check("back_idle", 64'(state), 64'd0);

    // Start held high throughout, operands changing during RUN.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick;
    lat = 1;
    while (!done && lat < 100) begin
      dividend = $urandom;
      divisor  = $urandom | 32'd1;
      tick;
      lat++;
    end
    check("hold1_lat", 64'(lat), 64'(LAT));
    check("hold1_q", 64'(quotient), 64'd333);
    check("hold1_r", 64'(remainder), 64'd1);
    $display("op hold1: 1000 / 3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    dividend = 32'd77;
    divisor  = 32'd10;
    tick;
    lat = 1;
    check("b2b_run", 64'(state), 64'd1);
    while (!done && lat < 100) begin
      dividend = $urandom;
      divisor  = $urandom | 32'd1;
      tick;
      lat++;
    end
    start = 1'b0;
    check("hold2_lat", 64'(lat), 64'(LAT));
    check("hold2_q", 64'(quotient), 64'd7);
    check("hold2_r", 64'(remainder), 64'd7);
    $display("op hold2: 77 / 10 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    tick;
    check("hold_idle", 64'(state), 64'd0);

    // Asynchronous reset in the middle of a run.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    #2;
    reset = 1'b0;
    #1;
    check("arst_q", 64'(quotient), 64'd0);
    check("arst_r", 64'(remainder), 64'd0);
    check("arst_dz", 64'(div_by_zero), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    $display("op arst: reset mid-run state=%0d q=%0d", state, quotient);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) check("arst_nodone", 64'(done), 64'd0);
    end
    reset = 1'b1;
    run_op(32'd9, 32'd4, "post_rst");

    // Random operands, nonzero divisors, occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? WIDTH'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 1;
      run_op(a, b, "rand");
      if ($urandom_range(0, 3) == 0) tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
